imem_fetch_responder: RTL and testbench
=======================================

IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of word count in the instruction store (256 words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from accepted fetch to data valid; legal range 1..4.
REQ-003 SHALL have port clock  input  1  single rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; asserted when 0 and sampled on clock rising edge.
REQ-005 SHALL have port pc  input  16  LC3 fetch address.
REQ-006 SHALL have port instrmem_rd  input  1  fetch request, one per cycle when high.
REQ-007 SHALL have port ld_en  input  1  program-load write strobe.
REQ-008 SHALL have port ld_addr  input  16  program-load word address.
REQ-009 SHALL have port ld_data  input  16  program-load word.
REQ-010 SHALL have port instr_dout  output  16  fetched instruction.
REQ-011 SHALL have port instr_valid  output  1  instr_dout is new this cycle.
REQ-012 SHALL have port addr_err  output  1  the word on instr_dout came from an out-of-range pc.
REQ-013 SHALL have port fetch_count  output  16  number of completed fetches since reset.

Function
REQ-014 SHALL accept a fetch on every clock edge where instrmem_rd=1; no back-pressure, full throughput of one fetch per cycle.
REQ-015 SHALL present the read word on instr_dout with instr_valid=1 exactly LATENCY cycles after acceptance; requests SHALL stay in order.
REQ-016 SHALL index the store with pc[DEPTH_LOG2-1:0]; if any pc bit at or above DEPTH_LOG2 is 1, SHALL return 16'h0000 (LC3 NOP) with addr_err=1 in the same data cycle.
REQ-017 SHALL hold instr_dout at its last value and drive instr_valid=0 and addr_err=0 in cycles with no completing fetch.
REQ-018 SHALL write ld_data to ld_addr[DEPTH_LOG2-1:0] on ld_en=1; out-of-range ld_addr writes SHALL be discarded.
REQ-019 SHALL sample the store on the accept edge (read-before-write), so a same-cycle write and fetch to the same word SHALL return the old data.
REQ-020 SHALL increment fetch_count on each instr_valid=1 cycle, saturating at 16'hFFFF with no wrap.

Reset
REQ-021 While reset=0, SHALL clear all in-flight fetches and drive instr_dout=16'h0000, instr_valid=0, addr_err=0, fetch_count=0.
REQ-022 A fetch in flight when reset asserts SHALL never complete; the first valid after release SHALL come from a request accepted after release.
REQ-023 Reset SHALL NOT clear store contents; ld_en SHALL be ignored while reset=0.

Configuration
REQ-024 With IMEM_PARITY_EN defined, SHALL store one even-parity bit per word on load, check it on read, and drive output parity_err  1  high alongside instr_valid on mismatch.
REQ-025 Without IMEM_PARITY_EN, SHALL have no parity storage and SHALL drive parity_err constant 0; the port SHALL exist in both builds.

Structure
REQ-026 Package imem_pkg_hdl SHALL hold typedef imem_word_t (16-bit), constant IMEM_NOP=16'h0000, IMEM_DEFAULT_LATENCY=2, IMEM_MAX_LATENCY=4.
REQ-027 The LATENCY-stage valid/data/err delay line SHALL be one sub-module, imem_fetch_pipe; the store and counter SHALL stay in imem_fetch_responder.

Verification
REQ-028 Load 16'h1021 at 0x0005, fetch pc=0x0005 (LATENCY=2) -> instr_valid=1, instr_dout=16'h1021 two cycles later, fetch_count=1.
REQ-029 Back-to-back fetches 0x0000..0x0003 over 4 cycles -> four consecutive valid words in order, no gaps, fetch_count=4.
REQ-030 Fetch pc=0x3000 with DEPTH_LOG2=8 -> instr_dout=16'h0000, addr_err=1 for one cycle.
REQ-031 Same-cycle ld_en to 0x0010 (16'hABCD over old 16'h5555) and fetch of 0x0010 -> 16'h5555 returned; next fetch returns 16'hABCD.
REQ-032 Fetch accepted, reset=0 asserted the next cycle -> no instr_valid on any later cycle for that request; outputs zero; store contents preserved.
REQ-033 IMEM_PARITY_EN build: corrupt a stored parity bit by force, fetch that word -> parity_err=1 with instr_valid; non-parity build -> parity_err stays 0.

Source files
------------

// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
package imem_pkg_hdl;

    typedef logic [15:0] imem_word_t;

    localparam imem_word_t IMEM_NOP = 16'h0000;
    localparam int IMEM_DEFAULT_LATENCY = 2;
    localparam int IMEM_MAX_LATENCY = 4;

    // One fetch result travelling down the delay line
    typedef struct packed {
        logic       valid;
        logic       addr_err;
        logic       parity_err;
        imem_word_t data;
    } imem_resp_t;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response bundle between a core (master) and the instruction store (slave).
interface imem_fetch_responder_if;
    import imem_pkg_hdl::*;

    logic [15:0] pc;
    logic        instrmem_rd;
    imem_word_t  instr_dout;
    logic        instr_valid;
    logic        addr_err;
    logic        parity_err;

    modport master (
        output pc, instrmem_rd,
        input  instr_dout, instr_valid, addr_err, parity_err
    );

    modport slave (
        input  pc, instrmem_rd,
        output instr_dout, instr_valid, addr_err, parity_err
    );

endinterface

// File: rtl/imem_fetch_responder_pipe.sv
// LATENCY-stage delay line for fetch results; the last stage holds its data
// when nothing completes and flags only accompany a valid word.
module imem_fetch_pipe
    import imem_pkg_hdl::*;
#(
    parameter int LATENCY = IMEM_DEFAULT_LATENCY
) (
    input  logic       clock,
    input  logic       reset,
    input  imem_resp_t req_i,
    output imem_resp_t resp_o,
    output logic       complete_o
);

    imem_resp_t stage_q [LATENCY];
    imem_resp_t stage_d [LATENCY];

    always_comb begin
        stage_d[0] = req_i;
        for (int i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        // Output stage: keep the previous word visible between completions
        stage_d[LATENCY-1].addr_err   = stage_d[LATENCY-1].valid & stage_d[LATENCY-1].addr_err;
        stage_d[LATENCY-1].parity_err = stage_d[LATENCY-1].valid & stage_d[LATENCY-1].parity_err;
        if (!stage_d[LATENCY-1].valid) begin
            stage_d[LATENCY-1].data = stage_q[LATENCY-1].data;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < LATENCY; i++) begin
            if (!reset) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign resp_o     = stage_q[LATENCY-1];
    assign complete_o = stage_d[LATENCY-1].valid;

endmodule

// File: rtl/imem_fetch_responder.sv
// LC3 instruction store with pipelined fetch responses and a saturating fetch counter.
// Define IMEM_PARITY_EN to add per-word even parity and drive parity_err on mismatch.
module imem_fetch_responder
    import imem_pkg_hdl::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = IMEM_DEFAULT_LATENCY
) (
    input  logic                         clock,
    input  logic                         reset,
    imem_fetch_responder_if.slave        fetch,
    input  logic                         ld_en,
    input  logic [15:0]                  ld_addr,
    input  imem_word_t                   ld_data,
    output logic [15:0]                  fetch_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    imem_word_t            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic                  rd_oob;
    logic                  wr_oob;
    logic                  wr_en;
    logic                  rd_perr;
    imem_resp_t            req;
    imem_resp_t            resp;
    logic                  complete;
    logic [15:0]           count_q;
    logic [15:0]           count_d;

    assign rd_idx = fetch.pc[DEPTH_LOG2-1:0];
    assign wr_idx = ld_addr[DEPTH_LOG2-1:0];
    assign rd_oob = (fetch.pc >> DEPTH_LOG2) != 16'd0;
    assign wr_oob = (ld_addr >> DEPTH_LOG2) != 16'd0;
    assign wr_en  = reset && ld_en && !wr_oob;

    // Store has no reset so a program survives a core reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= ld_data;
        end
    end

`ifdef IMEM_PARITY_EN
    logic [DEPTH-1:0] parity_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            parity_q[wr_idx] <= ^ld_data;
        end
    end

    assign rd_perr = (^mem_q[rd_idx]) != parity_q[rd_idx];
`else
    assign rd_perr = 1'b0;
`endif

    // The read is captured by the pipe on the accept edge, before any same-edge write lands
    always_comb begin
        req.valid      = fetch.instrmem_rd;
        req.addr_err   = rd_oob;
        req.parity_err = !rd_oob && rd_perr;
        req.data       = rd_oob ? IMEM_NOP : mem_q[rd_idx];
    end

    imem_fetch_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clock      (clock),
        .reset      (reset),
        .req_i      (req),
        .resp_o     (resp),
        .complete_o (complete)
    );

    always_comb begin
        count_d = count_q;
        if (complete && count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch.instr_dout  = resp.data;
    assign fetch.instr_valid = resp.valid;
    assign fetch.addr_err    = resp.addr_err;
    assign fetch.parity_err  = resp.parity_err;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: queue-based fetch model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_imem_fetch_responder;
    import imem_pkg_hdl::*;

    localparam int LAT = 2;
    localparam int NWORDS = 256;

    logic        clock;
    logic        reset;
    logic        ld_en;
    logic [15:0] ld_addr;
    imem_word_t  ld_data;
    logic [15:0] fetch_count;

    imem_fetch_responder_if fif ();

    imem_fetch_responder #(
        .DEPTH_LOG2 (8),
        .LATENCY    (LAT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .fetch       (fif.slave),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned due;
        logic [15:0] data;
        logic        err;
        logic        perr;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int unsigned edgeNum = 0;
    bit          checking = 0;
    int          corruptIdx = -1;
    logic [15:0] modelMem [NWORDS];
    exp_t        pend [$];
    logic        expValid = 0;
    logic        expErr = 0;
    logic        expPerr = 0;
    logic [15:0] expDout = 16'h0000;
    logic [15:0] expCount = 16'h0000;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic [15:0] pc,
                                 input logic le, input logic [15:0] la, input logic [15:0] ld);
        fif.instrmem_rd = rd;
        fif.pc          = pc;
        ld_en           = le;
        ld_addr         = la;
        ld_data         = ld;
        @(posedge clock);
        #1;
    endtask

    // Model: each accepted fetch emerges LAT edges later (visible after edge accept+LAT-1)
    always @(posedge clock) begin
        exp_t e;
        if (!reset) begin
            pend.delete();
            expValid = 0;
            expErr   = 0;
            expPerr  = 0;
            expDout  = 16'h0000;
            expCount = 16'h0000;
            checking = 1;
        end else begin
            if (fif.instrmem_rd) begin
                e.due  = edgeNum + LAT - 1;
                e.err  = (fif.pc >= NWORDS);
                e.data = e.err ? 16'h0000 : modelMem[fif.pc];
                e.perr = !e.err && (int'(fif.pc) == corruptIdx);
                pend.push_back(e);
            end
            if (ld_en && ld_addr < NWORDS) modelMem[ld_addr] = ld_data;
            expValid = 0;
            expErr   = 0;
            expPerr  = 0;
            if (pend.size() > 0 && pend[0].due == edgeNum) begin
                e = pend.pop_front();
                expValid = 1;
                expErr   = e.err;
                expPerr  = e.perr;
                expDout  = e.data;
                if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
            end
        end
        edgeNum++;
    end

    always @(negedge clock) begin
        if (checking) begin
            checkOutput("instr_valid", {15'd0, fif.instr_valid}, {15'd0, expValid});
            checkOutput("addr_err",    {15'd0, fif.addr_err},    {15'd0, expErr});
            checkOutput("parity_err",  {15'd0, fif.parity_err},  {15'd0, expPerr});
            checkOutput("instr_dout",  fif.instr_dout, expDout);
            checkOutput("fetch_count", fetch_count, expCount);
        end
    end

    initial begin
        clock = 0;
        reset = 0;
        fif.instrmem_rd = 0;
        fif.pc = 16'h0000;
        ld_en = 0;
        ld_addr = 16'h0000;
        ld_data = 16'h0000;

        repeat (3) applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("rst_valid", {15'd0, fif.instr_valid}, 16'h0000);
        checkOutput("rst_dout",  fif.instr_dout, 16'h0000);
        checkOutput("rst_err",   {15'd0, fif.addr_err}, 16'h0000);
        checkOutput("rst_count", fetch_count, 16'h0000);

        reset = 1;
        for (int i = 0; i < NWORDS; i++) applyStimulus(0, 16'h0000, 1, i[15:0], 16'h7000 + i[15:0]);
        applyStimulus(0, 16'h0000, 1, 16'h0005, 16'h1021);
        applyStimulus(0, 16'h0000, 1, 16'h0010, 16'h5555);

        // Single fetch, two-cycle latency
        applyStimulus(1, 16'h0005, 0, 16'h0000, 16'h0000);
        checkOutput("lat_not_early", {15'd0, fif.instr_valid}, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("fetch5_valid", {15'd0, fif.instr_valid}, 16'h0001);
        checkOutput("fetch5_dout",  fif.instr_dout, 16'h1021);
        checkOutput("fetch5_count", fetch_count, 16'h0001);

        // Back-to-back fetches
        for (int i = 0; i < 4; i++) applyStimulus(1, i[15:0], 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("b2b_last_dout", fif.instr_dout, 16'h7003);
        checkOutput("b2b_count",     fetch_count, 16'h0005);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("hold_dout",  fif.instr_dout, 16'h7003);
        checkOutput("hold_valid", {15'd0, fif.instr_valid}, 16'h0000);

        // Out-of-range fetch
        applyStimulus(1, 16'h3000, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("oob_dout", fif.instr_dout, 16'h0000);
        checkOutput("oob_err",  {15'd0, fif.addr_err}, 16'h0001);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("oob_err_clear", {15'd0, fif.addr_err}, 16'h0000);

        // Same-cycle write and fetch: old data first, new data next
        applyStimulus(1, 16'h0010, 1, 16'h0010, 16'hABCD);
        applyStimulus(1, 16'h0010, 0, 16'h0000, 16'h0000);
        checkOutput("rbw_old", fif.instr_dout, 16'h5555);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("rbw_new", fif.instr_dout, 16'hABCD);

        // Out-of-range load discarded (would alias onto word 5)
        applyStimulus(0, 16'h0000, 1, 16'h0105, 16'hFFFF);
        applyStimulus(1, 16'h0005, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("oob_load_ignored", fif.instr_dout, 16'h1021);

        // Reset with a fetch in flight and a load attempt during reset
        applyStimulus(1, 16'h0005, 0, 16'h0000, 16'h0000);
        reset = 0;
        applyStimulus(0, 16'h0000, 1, 16'h0005, 16'hDEAD);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("inflight_valid", {15'd0, fif.instr_valid}, 16'h0000);
        checkOutput("inflight_dout",  fif.instr_dout, 16'h0000);
        checkOutput("inflight_count", fetch_count, 16'h0000);
        reset = 1;
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("post_rst_valid", {15'd0, fif.instr_valid}, 16'h0000);
        applyStimulus(1, 16'h0005, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("store_kept", fif.instr_dout, 16'h1021);
        checkOutput("post_rst_count", fetch_count, 16'h0001);

`ifdef IMEM_PARITY_EN
        corruptIdx = 7;
        force dut.parity_q[7] = ~(^modelMem[7]);
        applyStimulus(1, 16'h0007, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("parity_err_hit", {15'd0, fif.parity_err}, 16'h0001);
        release dut.parity_q[7];
`else
        applyStimulus(1, 16'h0007, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("parity_err_off", {15'd0, fif.parity_err}, 16'h0000);
`endif

        // Stream enough fetches to saturate the counter
        for (int i = 0; i < 65540; i++) applyStimulus(1, 16'h0000, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        applyStimulus(0, 16'h0000, 0, 16'h0000, 16'h0000);
        checkOutput("count_saturated", fetch_count, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
